// File: rtl/game_countdown_timer.sv
// BCD mm:ss match countdown for Pong, one step per 1 Hz Tick.
// Optional expiry blink enabled by defining GAME_TIMER_BLINK_EN.
module game_countdown_timer #(
  parameter int StartMinutes = 2,
  parameter int StartSecTens = 0,
  parameter int StartSecOnes = 0
) (
  input  logic       Clock,
  input  logic       Reset,
  input  logic       Tick,
  input  logic       Start,
  input  logic       Pause,
  input  logic       Load,
  output logic [3:0] MinOnes,
  output logic [3:0] SecTens,
  output logic [3:0] SecOnes,
  output logic       Running,
  output logic       Expired,
  output logic       ExpiredPulse,
  output logic       Blink
);
  localparam logic [3:0] M0 = 4'(StartMinutes);
  localparam logic [3:0] T0 = 4'(StartSecTens);
  localparam logic [3:0] O0 = 4'(StartSecOnes);

  typedef enum logic [1:0] {IDLE, RUN, PAUSED, EXPIRED} state_t;

  state_t     state, nstate;
  logic [3:0] nmin, nten, nones;
  logic       npulse;
  logic       zero, last;

  assign zero = (MinOnes == 4'd0) && (SecTens == 4'd0) && (SecOnes == 4'd0);
  assign last = (MinOnes == 4'd0) && (SecTens == 4'd0) && (SecOnes == 4'd1);

  always_comb begin
    nstate = state;
    nmin   = MinOnes;
    nten   = SecTens;
    nones  = SecOnes;
    npulse = 1'b0;
    if (Load) begin
      nstate = IDLE;
      nmin   = M0;
      nten   = T0;
      nones  = O0;
    end else if (Start && !Pause && (state == IDLE || state == PAUSED)) begin
      if (zero) begin
        nstate = EXPIRED;
        npulse = 1'b1;
      end else begin
        nstate = RUN;
      end
    end else if (Pause && !Start && state == RUN) begin
      nstate = PAUSED;
    end else if (Tick && state == RUN) begin
      if (SecOnes != 4'd0) begin
        nones = SecOnes - 4'd1;
      end else if (SecTens != 4'd0) begin
        nones = 4'd9;
        nten  = SecTens - 4'd1;
      end else if (MinOnes != 4'd0) begin
        nones = 4'd9;
        nten  = 4'd5;
        nmin  = MinOnes - 4'd1;
      end
      // 0:01 -> 0:00 expires on the same edge as the decrement
      if (last) begin
        nstate = EXPIRED;
        npulse = 1'b1;
      end
    end
  end

`ifdef GAME_TIMER_BLINK_EN
  logic nblink;
  always_comb begin
    nblink = Blink;
    if (Load || (nstate == EXPIRED && state != EXPIRED))
      nblink = 1'b0;
    else if (state == EXPIRED && Tick)
      nblink = ~Blink;
  end
`else
  assign Blink = 1'b0;
`endif

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state        <= IDLE;
      MinOnes      <= M0;
      SecTens      <= T0;
      SecOnes      <= O0;
      Running      <= 1'b0;
      Expired      <= 1'b0;
      ExpiredPulse <= 1'b0;
`ifdef GAME_TIMER_BLINK_EN
      Blink        <= 1'b0;
`endif
    end else begin
      state        <= nstate;
      MinOnes      <= nmin;
      SecTens      <= nten;
      SecOnes      <= nones;
      Running      <= (nstate == RUN);
      Expired      <= (nstate == EXPIRED);
      ExpiredPulse <= npulse;
`ifdef GAME_TIMER_BLINK_EN
      Blink        <= nblink;
`endif
    end
  end
endmodule

// File: tb/tb_game_countdown_timer.sv
// Bench for game_countdown_timer: directed test-plan scenarios plus random
// stimulus checked against a seconds-count reference model.
module tb_game_countdown_timer;
  logic       Clock, Reset, Tick, Start, Pause, Load;
  logic [3:0] MinOnes, SecTens, SecOnes;
  logic       Running, Expired, ExpiredPulse, Blink;
  logic [3:0] MinOnes0, SecTens0, SecOnes0;
  logic       Running0, Expired0, ExpiredPulse0, Blink0;

  game_countdown_timer #(.StartMinutes(1), .StartSecTens(0), .StartSecOnes(5)) dut (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .Pause(Pause), .Load(Load),
    .MinOnes(MinOnes), .SecTens(SecTens), .SecOnes(SecOnes), .Running(Running),
    .Expired(Expired), .ExpiredPulse(ExpiredPulse), .Blink(Blink));

  game_countdown_timer #(.StartMinutes(0), .StartSecTens(0), .StartSecOnes(0)) dut0 (
    .Clock(Clock), .Reset(Reset), .Tick(Tick), .Start(Start), .Pause(Pause), .Load(Load),
    .MinOnes(MinOnes0), .SecTens(SecTens0), .SecOnes(SecOnes0), .Running(Running0),
    .Expired(Expired0), .ExpiredPulse(ExpiredPulse0), .Blink(Blink0));

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int n_checks = 0;
  int n_fail   = 0;

  localparam int START = 65;
  localparam int S_IDLE = 0, S_RUN = 1, S_PAUSED = 2, S_EXP = 3;
  int m_secs, m_st;
  bit m_pulse, m_blink;

  wire [15:0] dut_vec = {MinOnes, SecTens, SecOnes, Running, Expired, ExpiredPulse, Blink};

  function automatic logic [15:0] exp_vec();
    logic b;
`ifdef GAME_TIMER_BLINK_EN
    b = m_blink;
`else
    b = 1'b0;
`endif
    return {4'(m_secs / 60), 4'((m_secs % 60) / 10), 4'(m_secs % 10),
            m_st == S_RUN, m_st == S_EXP, m_pulse, b};
  endfunction

  function automatic void model_reset();
    m_secs = START; m_st = S_IDLE; m_pulse = 0; m_blink = 0;
  endfunction

  function automatic void model_step(bit t, bit s, bit p, bit l);
    m_pulse = 0;
    if (l) begin
      m_secs = START; m_st = S_IDLE; m_blink = 0;
    end else if (s && !p && (m_st == S_IDLE || m_st == S_PAUSED)) begin
      if (m_secs > 0) m_st = S_RUN;
      else begin m_st = S_EXP; m_pulse = 1; m_blink = 0; end
    end else if (p && !s && m_st == S_RUN) begin
      m_st = S_PAUSED;
    end else if (t) begin
      if (m_st == S_RUN) begin
        m_secs--;
        if (m_secs == 0) begin m_st = S_EXP; m_pulse = 1; m_blink = 0; end
      end else if (m_st == S_EXP) begin
        m_blink = !m_blink;
      end
    end
  endfunction

  task automatic cyc(input bit t, input bit s, input bit p, input bit l);
    Tick = t; Start = s; Pause = p; Load = l;
    @(posedge Clock); #1;
    model_step(t, s, p, l);
  endtask

  task automatic do_reset();
    Reset = 1; Tick = 0; Start = 0; Pause = 0; Load = 0;
    #3; Reset = 0;
    model_reset();
  endtask

  task automatic test_reset();
    Reset = 1; Tick = 0; Start = 0; Pause = 0; Load = 0;
    @(posedge Clock); #1;
    model_reset();
    n_checks++;
    if (dut_vec !== 16'h1050) begin
      n_fail++; $display("FAIL reset_state got=%h exp=%h", dut_vec, 16'h1050);
    end
    #2; Reset = 0;
    cyc(0, 0, 0, 0);
    n_checks++;
    if (dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL reset_idle got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_countdown();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 6; i++) begin
      cyc(1, 0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec() || Running !== 1'b1) begin
        n_fail++; $display("FAIL countdown[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if ({MinOnes, SecTens, SecOnes} !== 12'h059) begin
      n_fail++; $display("FAIL countdown_end got=%h exp=059", {MinOnes, SecTens, SecOnes});
    end
  endtask

  task automatic test_load_expire();
    for (int i = 0; i < 57; i++) cyc(1, 0, 0, 0);
    n_checks++;
    if ({MinOnes, SecTens, SecOnes} !== 12'h002) begin
      n_fail++; $display("FAIL at_0_02 got=%h exp=002", {MinOnes, SecTens, SecOnes});
    end
    cyc(0, 0, 0, 1);
    n_checks++;
    if (dut_vec !== 16'h1050) begin
      n_fail++; $display("FAIL load got=%h exp=%h", dut_vec, 16'h1050);
    end
    cyc(0, 1, 0, 0);
    for (int i = 1; i <= 65; i++) begin
      cyc(1, 0, 0, 0);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL expire_run[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
    n_checks++;
    if ({MinOnes, SecTens, SecOnes, Expired, ExpiredPulse, Running} !== 15'b000000000000110) begin
      n_fail++; $display("FAIL expire_edge got=%h%b%b", {MinOnes, SecTens, SecOnes}, Expired, ExpiredPulse);
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      n_checks++;
      if ({MinOnes, SecTens, SecOnes, Expired, ExpiredPulse} !== 14'b00000000000010) begin
        n_fail++; $display("FAIL expire_hold[%0d] got=%h%b%b", i, {MinOnes, SecTens, SecOnes}, Expired, ExpiredPulse);
      end
    end
  endtask

  task automatic test_pause();
    cyc(0, 0, 0, 1);
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 35; i++) cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    n_checks++;
    if ({MinOnes, SecTens, SecOnes} !== 12'h030 || Running !== 1'b0 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL pause_tick got=%h exp=%h", dut_vec, exp_vec());
    end
    for (int i = 0; i < 3; i++) begin
      cyc(1, 0, 0, 0);
      n_checks++;
      if ({MinOnes, SecTens, SecOnes} !== 12'h030 || Running !== 1'b0) begin
        n_fail++; $display("FAIL paused_hold[%0d] got=%h", i, dut_vec);
      end
    end
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    n_checks++;
    if ({MinOnes, SecTens, SecOnes} !== 12'h029 || Running !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL resume got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_start_pause_both();
    for (int i = 0; i < 19; i++) cyc(1, 0, 0, 0);
    cyc(1, 1, 1, 0);
    n_checks++;
    if ({MinOnes, SecTens, SecOnes} !== 12'h009 || Running !== 1'b1 || dut_vec !== exp_vec()) begin
      n_fail++; $display("FAIL start_pause_both got=%h exp=%h", dut_vec, exp_vec());
    end
  endtask

  task automatic test_zero_start();
    do_reset();
    cyc(0, 1, 0, 0);
    n_checks++;
    if ({MinOnes0, SecTens0, SecOnes0, Running0, Expired0, ExpiredPulse0} !== 15'b000000000000011) begin
      n_fail++; $display("FAIL zero_start got=%h r%b e%b p%b exp=000 r0 e1 p1",
                         {MinOnes0, SecTens0, SecOnes0}, Running0, Expired0, ExpiredPulse0);
    end
    cyc(0, 0, 0, 0);
    n_checks++;
    if ({Expired0, ExpiredPulse0} !== 2'b10) begin
      n_fail++; $display("FAIL zero_pulse_len got=%b%b exp=10", Expired0, ExpiredPulse0);
    end
  endtask

  task automatic test_async_reset_blink();
    for (int i = 0; i < 18; i++) cyc(1, 0, 0, 0);
    n_checks++;
    if ({MinOnes, SecTens, SecOnes} !== 12'h047 || Running !== 1'b1) begin
      n_fail++; $display("FAIL at_0_47 got=%h", dut_vec);
    end
    #1; Reset = 1; #1;
    n_checks++;
    if (dut_vec !== 16'h1050) begin
      n_fail++; $display("FAIL async_reset got=%h exp=%h", dut_vec, 16'h1050);
    end
    #1; Reset = 0;
    model_reset();
    cyc(0, 1, 0, 0);
    for (int i = 0; i < 65; i++) cyc(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      logic eb;
      cyc(1, 0, 0, 0);
`ifdef GAME_TIMER_BLINK_EN
      eb = (i % 2 == 0);
`else
      eb = 1'b0;
`endif
      n_checks++;
      if (Blink !== eb || Expired !== 1'b1) begin
        n_fail++; $display("FAIL blink[%0d] got=%b exp=%b", i, Blink, eb);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      bit t, s, p, l;
      t = ($urandom_range(0, 1) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 9) == 0);
      l = ($urandom_range(0, 99) == 0);
      cyc(t, s, p, l);
      n_checks++;
      if (dut_vec !== exp_vec()) begin
        n_fail++; $display("FAIL random[%0d] got=%h exp=%h", i, dut_vec, exp_vec());
      end
    end
  endtask

  initial begin
    Reset = 1; Tick = 0; Start = 0; Pause = 0; Load = 0;
    model_reset();
    test_reset();
    test_countdown();
    test_load_expire();
    test_pause();
    test_start_pause_both();
    test_zero_start();
    test_async_reset_blink();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
